riscv_imem_dual_arb: RTL

- Sits directly downstream of the dual-fetch core's two instruction memory ports (imemreq0/imemresp0, imemreq1/imemresp1).
- Merges both request streams onto one single-ported instruction memory port.
- Records which port issued each request and steers every memory response back to the originating port, in order.
- Lets the dual-fetch core run against a single-ported imem model or cache.

---
 rtl/riscv_imem_dual_arb.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/riscv_imem_dual_arb.sv
// ---------------------------------------------------------------------------
// riscv_imem_dual_arb
//
// Merges the two instruction-fetch request streams of a dual-fetch core onto
// one single-ported instruction memory. A small tag FIFO records which fetch
// port issued each accepted request. In-order memory responses are steered
// back to that port.
//
// Optional build macro: RISCV_IMEM_DUAL_ARB_PERF_EN
//   defined   -> grant0_cnt / grant1_cnt / conflict_cnt are live counters
//   undefined -> the counter ports are tied to zero and no flops are built
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   imemreq{0,1}_msg/val/rdy   fetch-port requests (67-bit mem req msg)
//   imemresp{0,1}_msg/val      fetch-port responses (35-bit mem resp msg)
//   memreq_msg/val/rdy         merged request to memory
//   memresp_msg/val            in-order memory response
//   resp_orphan                sticky: response seen with nothing outstanding
//   grant0_cnt, grant1_cnt     per-port issue counts (perf build)
//   conflict_cnt               cycles with both requests valid (perf build)
// ---------------------------------------------------------------------------
module riscv_imem_dual_arb #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,

    input  logic [66:0]      imemreq0_msg,
    input  logic             imemreq0_val,
    output logic             imemreq0_rdy,
    output logic [34:0]      imemresp0_msg,
    output logic             imemresp0_val,

    input  logic [66:0]      imemreq1_msg,
    input  logic             imemreq1_val,
    output logic             imemreq1_rdy,
    output logic [34:0]      imemresp1_msg,
    output logic             imemresp1_val,

    output logic [66:0]      memreq_msg,
    output logic             memreq_val,
    input  logic             memreq_rdy,
    input  logic [34:0]      memresp_msg,
    input  logic             memresp_val,

    output logic             resp_orphan,
    output logic [CNT_W-1:0] grant0_cnt,
    output logic [CNT_W-1:0] grant1_cnt,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = PTR_W + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Tag FIFO storage and control state
    logic             tag_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             prio_q, prio_d;
    logic             orphan_q, orphan_d;

    logic any_val, not_full, can_issue, winner, fire;
    logic empty, bypass, push, pop, route_val, route_tag, orphan_evt;

    // Arbitration and issue
    always_comb begin
        any_val   = imemreq0_val || imemreq1_val;
        not_full  = (count_q < DEPTH_C);
        can_issue = !reset && memreq_rdy && not_full;
        // Both valid: priority pointer decides; otherwise whichever is valid.
        winner    = (imemreq0_val && imemreq1_val) ? prio_q : imemreq1_val;

        memreq_val   = !reset && any_val && not_full;
        memreq_msg   = winner ? imemreq1_msg : imemreq0_msg;
        imemreq0_rdy = can_issue && !winner;
        imemreq1_rdy = can_issue && winner;

        fire = memreq_val && memreq_rdy;
    end

    // Response routing
    always_comb begin
        empty = (count_q == '0);
        // An empty FIFO with a same-cycle issue lets the response bypass the
        // FIFO entirely and go straight to the winner.
        bypass     = fire && memresp_val && empty;
        pop        = memresp_val && !empty;
        push       = fire && !bypass;
        orphan_evt = memresp_val && empty && !fire;

        route_val = !reset && (pop || bypass);
        route_tag = bypass ? winner : tag_q[rptr_q];

        imemresp0_msg = memresp_msg;
        imemresp1_msg = memresp_msg;
        imemresp0_val = route_val && !route_tag;
        imemresp1_val = route_val && route_tag;
    end

    // Next-state
    always_comb begin
        wptr_d = wptr_q + PTR_W'(push);
        rptr_d = rptr_q + PTR_W'(pop);
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        prio_d   = fire ? ~winner : prio_q;
        orphan_d = orphan_q || orphan_evt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            prio_q   <= 1'b0;
            orphan_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            prio_q   <= prio_d;
            orphan_q <= orphan_d;
        end
    end

    // Tag storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[wptr_q] <= winner;
        end
    end

    assign resp_orphan = orphan_q;

`ifdef RISCV_IMEM_DUAL_ARB_PERF_EN
    logic [CNT_W-1:0] grant0_q, grant1_q, conflict_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            grant0_q   <= '0;
            grant1_q   <= '0;
            conflict_q <= '0;
        end else begin
            if (fire && !winner) grant0_q <= grant0_q + CNT_W'(1);
            if (fire && winner)  grant1_q <= grant1_q + CNT_W'(1);
            if (imemreq0_val && imemreq1_val) conflict_q <= conflict_q + CNT_W'(1);
        end
    end

    assign grant0_cnt   = grant0_q;
    assign grant1_cnt   = grant1_q;
    assign conflict_cnt = conflict_q;
`else
    assign grant0_cnt   = '0;
    assign grant1_cnt   = '0;
    assign conflict_cnt = '0;
`endif

endmodule
